// File: rtl/refill_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// refill_scheduler_pkg
//   Shared merge-tree definitions: the refill scheduler FSM state encoding
//   and the default tree / block geometry.
// ---------------------------------------------------------------------------
package refill_scheduler_pkg;

  // Default geometry: 4 tree leaves, 8 records per buffered block.
  localparam int DEF_W_LOG = 2;
  localparam int DEF_P_LOG = 3;

  // Refill scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin first-one finder. Searches req upward starting
//   at ptr+1 (modulo N), wrapping from N-1 to 0; ptr itself is checked last.
//
//   Ports
//     req   : in  N       request vector
//     ptr   : in  W_LOG   last granted index
//     idx   : out W_LOG   first requesting index after ptr
//     found : out 1       any bit of req set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int W_LOG = 2
) (
  input  logic [(1<<W_LOG)-1:0] req,
  input  logic [W_LOG-1:0]      ptr,
  output logic [W_LOG-1:0]      idx,
  output logic                  found
);

  localparam int N = 1 << W_LOG;

  logic [W_LOG-1:0] cand;

  // Walk from the farthest candidate to the nearest so that the last hit
  // written is the closest one after ptr. The W_LOG-bit add wraps modulo N.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = ptr + k[W_LOG-1:0];
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/refill_scheduler.sv
// ---------------------------------------------------------------------------
// refill_scheduler
//   Issues refill requests for merge-tree leaves whose filler buffer holds a
//   block, the leaf has room, and no refill is already in flight. Channels
//   are served round-robin, at most one issue every two cycles (the HOLD
//   cycle covers the filler queue-full flag latency). Completions reported
//   on DONE_* retire the in-flight bit; a completion for a channel that is
//   not in flight raises the sticky ERR flag.
//
//   Ports
//     CLK             : in  1        clock, rising edge
//     RST_N           : in  1        asynchronous active-low reset
//     ENABLE          : in  1        permit new issues
//     LEAF_NEED       : in  N        leaf i can accept data
//     BUF_EMP         : in  N        filler buffer i is empty
//     QUEUE_FULL      : in  1        filler request queue full
//     I_REQUEST       : out W_LOG    channel being issued (held between issues)
//     I_REQUEST_VALID : out 1        one-cycle issue strobe
//     DONE_VALID      : in  1        filler delivered last record of a block
//     DONE_IDX        : in  W_LOG    channel that completed
//     OUTSTANDING     : out N        in-flight mask
//     OUT_CNT         : out W_LOG+1  popcount of OUTSTANDING
//     ERR             : out 1        sticky protocol error
// ---------------------------------------------------------------------------
module refill_scheduler
  import refill_scheduler_pkg::*;
#(
  parameter int W_LOG = DEF_W_LOG,
  parameter int P_LOG = DEF_P_LOG
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic [(1<<W_LOG)-1:0] LEAF_NEED,
  input  logic [(1<<W_LOG)-1:0] BUF_EMP,
  input  logic                  QUEUE_FULL,
  output logic [W_LOG-1:0]      I_REQUEST,
  output logic                  I_REQUEST_VALID,
  input  logic                  DONE_VALID,
  input  logic [W_LOG-1:0]      DONE_IDX,
  output logic [(1<<W_LOG)-1:0] OUTSTANDING,
  output logic [W_LOG:0]        OUT_CNT,
  output logic                  ERR
);

  localparam int N = 1 << W_LOG;
  localparam logic [W_LOG:0] CNT_ONE = {{W_LOG{1'b0}}, 1'b1};

  // DONE_VALID already marks the last record of a block, so the block size
  // only matters as a geometry sanity check here.
  if (P_LOG < 1 || W_LOG < 1) begin : g_bad_geometry
    $error("refill_scheduler: W_LOG and P_LOG must both be at least 1");
  end

  sched_state_e     state_q, state_d;
  logic [W_LOG-1:0] ptr_q, ptr_d;
  logic [W_LOG-1:0] req_q, req_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     out_q, out_d;
  logic [W_LOG:0]   cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N-1:0]     eligible;
  logic [W_LOG-1:0] pick_idx;
  logic             pick_found;
  logic             grant;
  logic             done_hit;
  logic [N-1:0]     grant_mask;
  logic [N-1:0]     clear_mask;

  assign eligible = LEAF_NEED & ~BUF_EMP & ~out_q;

  rr_pick #(
    .W_LOG (W_LOG)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    req_d      = req_q;
    valid_d    = 1'b0;
    grant      = 1'b0;
    err_d      = err_q;
    grant_mask = '0;
    clear_mask = '0;
    cnt_d      = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (!QUEUE_FULL && pick_found) begin
          grant   = 1'b1;
          req_d   = pick_idx;
          valid_d = 1'b1;
          ptr_d   = pick_idx;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ENABLE ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A grant never targets an in-flight channel, so a same-index DONE in the
    // same cycle always lands in the error branch and never clears the bit.
    done_hit = DONE_VALID & out_q[DONE_IDX];
    if (grant)    grant_mask = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    if (done_hit) clear_mask = {{(N-1){1'b0}}, 1'b1} << DONE_IDX;
    if (DONE_VALID && !done_hit) err_d = 1'b1;

    out_d = (out_q | grant_mask) & ~clear_mask;

    unique case ({grant, done_hit})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= W_LOG'(N - 1);  // first search starts at index 0
      req_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign I_REQUEST       = req_q;
  assign I_REQUEST_VALID = valid_q;
  assign OUTSTANDING     = out_q;
  assign OUT_CNT         = cnt_q;
  assign ERR             = err_q;

endmodule

// File: tb/tb_refill_scheduler.sv
// ---------------------------------------------------------------------------
// tb_refill_scheduler
//   Directed, table-driven bench for refill_scheduler (W_LOG=2), with
//   hand-written sequences for queue-full stalls, pointer wrap, sticky ERR
//   and asynchronous reset during an issue strobe.
// ---------------------------------------------------------------------------
module tb_refill_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] leaf_need;
  logic [3:0] buf_emp;
  logic       queue_full;
  logic [1:0] i_request;
  logic       i_request_valid;
  logic       done_valid;
  logic [1:0] done_idx;
  logic [3:0] outstanding;
  logic [2:0] out_cnt;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  refill_scheduler #(
    .W_LOG (2),
    .P_LOG (3)
  ) dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .ENABLE          (enable),
    .LEAF_NEED       (leaf_need),
    .BUF_EMP         (buf_emp),
    .QUEUE_FULL      (queue_full),
    .I_REQUEST       (i_request),
    .I_REQUEST_VALID (i_request_valid),
    .DONE_VALID      (done_valid),
    .DONE_IDX        (done_idx),
    .OUTSTANDING     (outstanding),
    .OUT_CNT         (out_cnt),
    .ERR             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] bemp;
    logic       dv;
    logic [1:0] di;
    logic       exp_v;
    logic [1:0] exp_req;
    logic [3:0] exp_out;
    logic [2:0] exp_cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic en, logic [3:0] bemp, logic dv, logic [1:0] di,
                              logic ev, logic [1:0] er, logic [3:0] eo, logic [2:0] ec);
    vec_t v;
    v.en = en; v.bemp = bemp; v.dv = dv; v.di = di;
    v.exp_v = ev; v.exp_req = er; v.exp_out = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Advance one clock edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pull reset low between edges, verify the outputs cleared asynchronously,
  // then release right after the next edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", i_request_valid, 0);
    chk("rst_req",   i_request, 0);
    chk("rst_out",   outstanding, 0);
    chk("rst_cnt",   out_cnt, 0);
    chk("rst_err",   err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b1;
    leaf_need  = 4'hF;
    buf_emp    = 4'h0;
    queue_full = 1'b0;
    done_valid = 1'b0;
    done_idx   = 2'd0;
    #1;

    //            en  bemp dv di  v  req  out    cnt
    vecs[0]  = mk(1, 4'h0, 0, 0,  0, 0, 4'h0, 3'd0);  // IDLE -> ARB
    vecs[1]  = mk(1, 4'h0, 0, 0,  1, 0, 4'h1, 3'd1);
    vecs[2]  = mk(1, 4'h0, 0, 0,  0, 0, 4'h1, 3'd1);
    vecs[3]  = mk(1, 4'h0, 0, 0,  1, 1, 4'h3, 3'd2);
    vecs[4]  = mk(1, 4'h0, 0, 0,  0, 1, 4'h3, 3'd2);
    vecs[5]  = mk(1, 4'h0, 0, 0,  1, 2, 4'h7, 3'd3);
    vecs[6]  = mk(1, 4'h0, 0, 0,  0, 2, 4'h7, 3'd3);
    vecs[7]  = mk(1, 4'h0, 0, 0,  1, 3, 4'hF, 3'd4);
    vecs[8]  = mk(1, 4'h0, 0, 0,  0, 3, 4'hF, 3'd4);
    vecs[9]  = mk(1, 4'h0, 0, 0,  0, 3, 4'hF, 3'd4);  // nothing eligible
    vecs[10] = mk(1, 4'h0, 0, 0,  0, 3, 4'hF, 3'd4);
    vecs[11] = mk(1, 4'h0, 1, 2,  0, 3, 4'hB, 3'd3);  // DONE 2
    vecs[12] = mk(1, 4'h0, 1, 0,  1, 2, 4'hE, 3'd3);  // reissue 2 + DONE 0
    vecs[13] = mk(1, 4'h0, 0, 0,  0, 2, 4'hE, 3'd3);
    vecs[14] = mk(1, 4'h0, 0, 0,  1, 0, 4'hF, 3'd4);  // ptr 2 -> wraps to 0
    vecs[15] = mk(1, 4'h0, 0, 0,  0, 0, 4'hF, 3'd4);
    vecs[16] = mk(1, 4'h0, 0, 0,  0, 0, 4'hF, 3'd4);
    vecs[17] = mk(0, 4'h0, 1, 1,  0, 0, 4'hD, 3'd3);  // ENABLE low, DONE still taken
    vecs[18] = mk(0, 4'h0, 0, 0,  0, 0, 4'hD, 3'd3);  // IDLE, no issue
    vecs[19] = mk(1, 4'h0, 0, 0,  0, 0, 4'hD, 3'd3);  // IDLE -> ARB
    vecs[20] = mk(1, 4'h0, 0, 0,  1, 1, 4'hF, 3'd4);
    vecs[21] = mk(1, 4'h0, 0, 0,  0, 1, 4'hF, 3'd4);
    vecs[22] = mk(1, 4'h8, 1, 3,  0, 1, 4'h7, 3'd3);  // DONE 3
    vecs[23] = mk(1, 4'h8, 0, 0,  0, 1, 4'h7, 3'd3);  // buffer 3 empty: blocked
    vecs[24] = mk(1, 4'h0, 0, 0,  1, 3, 4'hF, 3'd4);

    apply_reset();

    for (int i = 0; i < NV; i++) begin
      enable     = vecs[i].en;
      buf_emp    = vecs[i].bemp;
      done_valid = vecs[i].dv;
      done_idx   = vecs[i].di;
      tick();
      $display("vec %0d: v=%0b req=%0d out=%b cnt=%0d err=%0b",
               i, i_request_valid, i_request, outstanding, out_cnt, err);
      chk($sformatf("vec%0d_valid", i), i_request_valid, vecs[i].exp_v);
      chk($sformatf("vec%0d_req", i),   i_request,       vecs[i].exp_req);
      chk($sformatf("vec%0d_out", i),   outstanding,     vecs[i].exp_out);
      chk($sformatf("vec%0d_cnt", i),   out_cnt,         vecs[i].exp_cnt);
      chk($sformatf("vec%0d_err", i),   err,             0);
    end
    done_valid = 1'b0;
    buf_emp    = 4'h0;

    // Queue full: no strobe while held (1 IDLE->ARB edge + 5 stalled ARB
    // edges), first strobe one cycle after it drops.
    apply_reset();
    enable = 1'b1; leaf_need = 4'hF; queue_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("qfull cycle %0d: v=%0b", i, i_request_valid);
      chk($sformatf("qfull%0d_valid", i), i_request_valid, 0);
    end
    queue_full = 1'b0;
    tick();
    $display("qfull release: v=%0b req=%0d", i_request_valid, i_request);
    chk("qfull_rel_valid", i_request_valid, 1);
    chk("qfull_rel_req",   i_request, 0);

    // Wrap: ptr=1, only channel 0 eligible -> grant 0.
    apply_reset();
    leaf_need = 4'b0010;
    tick(); tick();
    chk("wrapA_first_req", i_request, 1);
    leaf_need = 4'b0001;
    tick();
    chk("wrapA_hold_valid", i_request_valid, 0);
    tick();
    $display("wrap A: v=%0b req=%0d", i_request_valid, i_request);
    chk("wrapA_valid", i_request_valid, 1);
    chk("wrapA_req",   i_request, 0);

    // ptr=1, channels 0 and 3 eligible -> grant 3.
    apply_reset();
    leaf_need = 4'b0010;
    tick(); tick();
    chk("wrapB_first_req", i_request, 1);
    leaf_need = 4'b1001;
    tick(); tick();
    $display("wrap B: v=%0b req=%0d", i_request_valid, i_request);
    chk("wrapB_valid", i_request_valid, 1);
    chk("wrapB_req",   i_request, 3);

    // Sticky ERR on DONE for a channel not in flight.
    apply_reset();
    leaf_need = 4'h0;
    done_valid = 1'b1; done_idx = 2'd1;
    tick();
    done_valid = 1'b0;
    $display("bad done: err=%0b out=%b cnt=%0d", err, outstanding, out_cnt);
    chk("err_set", err, 1);
    chk("err_out", outstanding, 0);
    chk("err_cnt", out_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("err_sticky%0d", i), err, 1);
    end

    // Reset asserted while the strobe is high clears everything between edges.
    leaf_need = 4'hF;
    tick();
    $display("pre-reset strobe: v=%0b req=%0d out=%b", i_request_valid, i_request, outstanding);
    chk("mid_pre_valid", i_request_valid, 1);
    chk("mid_pre_out",   outstanding, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: v=%0b req=%0d out=%b cnt=%0d err=%0b",
             i_request_valid, i_request, outstanding, out_cnt, err);
    chk("mid_rst_valid", i_request_valid, 0);
    chk("mid_rst_req",   i_request, 0);
    chk("mid_rst_out",   outstanding, 0);
    chk("mid_rst_cnt",   out_cnt, 0);
    chk("mid_rst_err",   err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_req", i_request, 0);
    chk("post_rst_valid", i_request_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
